// File: rtl/vga_timing_param_if.sv
// Timing bundle from the VGA timing generator to the draw modules.
// The master drives all signals. Slaves only read them.
interface vga_timing_param_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             line_start;
  logic             frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator with a pixel enable and wrap strobes.
// Every output is registered from the next counter value, so all flags line up with hcount/vcount.
module vga_timing_param #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  vga_timing_param_if.master  tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CNT_W == 0 || CNT_W > 31 ||
      longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_param_check
    $fatal(1, "vga_timing_param: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (ce) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end

    // Flags decode the next counter value so they land in the same cycle as the counters.
    hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    hblnk_d = (hcount_d >= H_ACT);
    vblnk_d = (vcount_d >= V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim.hcount      = hcount_q;
  assign tim.vcount      = vcount_q;
  assign tim.hsync       = hsync_q;
  assign tim.vsync       = vsync_q;
  assign tim.hblnk       = hblnk_q;
  assign tim.vblnk       = vblnk_q;
  assign tim.line_start  = line_start_q;
  assign tim.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: a small 12x7 instance (active-high syncs) and the default 1344x806 instance.
// Outputs are packed as {hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start}.
module tb_vga_timing_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_param_if #(.CNT_W(4))  s_if ();
  vga_timing_param_if #(.CNT_W(11)) d_if ();

  vga_timing_param #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .tim (s_if.master)
  );

  vga_timing_param u_dflt (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .tim (d_if.master)
  );

  typedef struct {
    logic       r;
    logic       c;
    logic [3:0] h;
    logic [3:0] v;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pack_s();
    return {s_if.hcount, s_if.vcount, s_if.hsync, s_if.vsync,
            s_if.hblnk, s_if.vblnk, s_if.line_start, s_if.frame_start};
  endfunction

  function automatic logic [27:0] pack_d();
    return {d_if.hcount, d_if.vcount, d_if.hsync, d_if.vsync,
            d_if.hblnk, d_if.vblnk, d_if.line_start, d_if.frame_start};
  endfunction

  // n = ce pulses since reset, c = ce of the cycle just taken.
  function automatic logic [13:0] exp_small(input int n, input logic c);
    int h = n % 12;
    int v = (n / 12) % 7;
    logic wrap = c && (n > 0) && (h == 0);
    return {4'(h), 4'(v), (h == 9 || h == 10), (v == 5), (h >= 8), (v >= 4),
            wrap, wrap && (v == 0)};
  endfunction

  function automatic logic [27:0] exp_dflt(input int n, input logic c);
    int h = n % 1344;
    int v = (n / 1344) % 806;
    logic wrap = c && (n > 0) && (h == 0);
    return {11'(h), 11'(v), !(h >= 1048 && h <= 1183), !(v >= 771 && v <= 776),
            (h >= 1024), (v >= 768), wrap, wrap && (v == 0)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic c;

    //           r     c     h      v      hs    vs    hb    vb    ls    fs
    tbl.push_back('{1'b0, 1'b1, 4'd1,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd1,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd3,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd4,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd5,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd6,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd7,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd8,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd9,  4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd10, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_small", 64'(pack_s()), 64'(14'b0000_0000_000000));
    chk("reset_dflt",  64'(pack_d()), 64'({11'd0, 11'd0, 6'b110000}));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c);
      chk($sformatf("vec%0d", i), 64'(pack_s()),
          64'({tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb,
               tbl[i].ls, tbl[i].fs}));
    end

    // Full small frame: frame_start exactly on the 84th ce pulse.
    for (n = 1; n <= 84; n++) begin
      step(1'b0, 1'b1);
      chk("frame_run", 64'(pack_s()), 64'(exp_small(n, 1'b1)));
    end

    // ce pattern 1,0,0,1: 168 clocks carry 84 pulses and end on the next frame_start.
    n = 84;
    for (int k = 0; k < 168; k++) begin
      c = (k % 4 == 0) || (k % 4 == 3);
      if (c) n++;
      step(1'b0, c);
      chk("ce_gated", 64'(pack_s()), 64'(exp_small(n, c)));
    end
    chk("ce_gated_frame_start", 64'(s_if.frame_start), 64'(1'b1));

    // Reset mid-frame at (4,3): clean (0,0), then a full frame before the next frame_start.
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1);
    chk("pre_reset_pos", 64'({s_if.hcount, s_if.vcount}), 64'({4'd4, 4'd3}));
    step(1'b1, 1'b1);
    chk("mid_reset", 64'(pack_s()), 64'(exp_small(0, 1'b1)));
    for (n = 1; n <= 84; n++) begin
      step(1'b0, 1'b1);
      chk("post_reset_run", 64'(pack_s()), 64'(exp_small(n, 1'b1)));
    end

    // Default geometry: a few full lines covering hsync, hblnk and the line wrap.
    step(1'b1, 1'b1);
    chk("reset_dflt2", 64'(pack_d()), 64'(exp_dflt(0, 1'b1)));
    for (n = 1; n <= 2 * 1344 + 10; n++) begin
      step(1'b0, 1'b1);
      chk("dflt_line", 64'(pack_d()), 64'(exp_dflt(n, 1'b1)));
    end
    step(1'b0, 1'b0);
    chk("dflt_hold", 64'(pack_d()), 64'(exp_dflt(n - 1, 1'b0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
- Parametrised VGA timing generator. Next generation of the fixed 1024x768@60 timing block.
- Resolution, porches, sync widths, sync polarities and counter width are set by parameters.
- Adds a pixel clock-enable, frame-start and line-start strobes, and a registered output pipeline that keeps every output coherent.
- Sits at the head of the video chain. It feeds timing_if (hcount, vcount, hsync, vsync, hblnk, vblnk) to the draw modules.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- CNT_W, 11, width of hcount/vcount

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel enable; counters advance only when 1
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- hblnk  out  1  1 when hcount >= H_ACTIVE
- vblnk  out  1  1 when vcount >= V_ACTIVE
- line_start  out  1  one-clock strobe, hcount just wrapped to 0
- frame_start  out  1  one-clock strobe, (hcount,vcount) just wrapped to (0,0)

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = 806 (defaults).
- Elaboration check: fatal if H_TOTAL or V_TOTAL > 2^CNT_W, or if any parameter is 0.
- Registered outputs:
  - All outputs are registers, computed from the next counter value.
  - Every output in a given cycle therefore describes the same (hcount,vcount); there is no skew between counters and flags.
- Reset, while rst=1 at a clk edge (overrides ce):
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL (inactive levels).
  - line_start=0, frame_start=0.
- Advance on ce=1:
  - If hcount < H_TOTAL-1: hcount+1, vcount unchanged.
  - Otherwise hcount=0 and vcount advances: vcount+1, or 0 if vcount = V_TOTAL-1.
- Hold on ce=0: all counters and levels hold. line_start and frame_start are forced to 0.
- hsync: active iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1. Output level = active ? HSYNC_POL : ~HSYNC_POL.
- vsync: active iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1. Decoded on vcount only, so it changes in the same cycle hcount wraps to 0.
- line_start: 1 for exactly one clk in the cycle the outputs first show hcount=0 after a wrap from H_TOTAL-1.
- frame_start: 1 only in the cycle outputs show (0,0) after a wrap from (H_TOTAL-1,V_TOTAL-1). It implies line_start=1 in the same cycle.
- After reset release: the first (0,0) is not a wrap, so no strobe fires. The first frame_start arrives after one full frame of ce pulses, i.e. H_TOTAL*V_TOTAL ce cycles.
- Reset mid-frame: the next cycle shows (0,0) with inactive syncs and strobes 0. No partial strobe is emitted.
- Wrap-around: hcount never reaches H_TOTAL and vcount never reaches V_TOTAL; no overflow at any CNT_W satisfying the check.
- Latency: 1 clk from a ce=1 edge to the updated outputs.

Test Plan:
- Reset then ce=1 constantly, defaults -> hcount counts 0..1343 and wraps; vcount increments at each wrap. After 1344*806 = 1,083,264 clks: frame_start=1, line_start=1, (0,0).
- Sample hsync across one line (defaults) -> low exactly for hcount 1048..1183 (136 clks), high elsewhere. hblnk=1 for hcount 1024..1343.
- Sample vsync across one frame -> low exactly for vcount 771..776, transitioning when hcount=0. vblnk=1 for vcount 768..805.
- ce toggled 1,0,0,1 repeatedly -> counters advance only on ce=1 cycles, strobes never high when ce=0. One frame takes 2*1,083,264 clks at 50% ce.
- rst pulsed at (500,400) -> next cycle shows (0,0), hsync=vsync=1, strobes 0, and no frame_start until a full frame later.
- Override to H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=1, VSYNC_POL=1, CNT_W=4 -> H_TOTAL=12, V_TOTAL=7. hsync high at hcount 9..10, vsync high at vcount 5, frame_start every 84 ce cycles.
